// File: rtl/mul_div_unit_if.sv
// ---------------------------------------------------------------------------
// mul_div_unit_if
// Bundle between the EX stage (master) and the multiply/divide unit (slave).
//   start        issue pulse for MULT/MULTU/DIV/DIVU
//   op           0 = multiply, 1 = divide
//   Sign         1 = signed, 0 = unsigned
//   A, B         operands (rs, rt)
//   hi_we/lo_we  MTHI/MTLO write strobes, data on wdata
//   busy         operation in flight, EX must stall
//   done         one-cycle pulse after HI/LO take an operation result
//   hi, lo       architectural HI/LO registers
// ---------------------------------------------------------------------------
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic             Sign;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, Sign, A, B, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, Sign, A, B, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Iterative radix-2 multiply/divide unit owning HI/LO. One operation takes
// WIDTH+2 cycles from the start edge to the done pulse.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high, clears all state
//   bus    mul_div_unit_if.slave (start/op/Sign/A/B, MTHI/MTLO, busy/done/hi/lo)
//   abort  only when MDU_ABORT_EN is defined: flush of an in-flight operation
// Optional feature macro: MDU_ABORT_EN
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = 32'hFFFFFFFF
) (
    input  logic           clk,
    input  logic           reset,
`ifdef MDU_ABORT_EN
    input  logic           abort,
`endif
    mul_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             q_neg;
    logic             r_neg;
    logic             b_zero;
    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] lower;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;
    logic             abort_now;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     mul_next;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

`ifdef MDU_ABORT_EN
    assign abort_now = abort;
`else
    assign abort_now = 1'b0;
`endif

    // Operand magnitudes; INT_MIN maps onto itself, which is the correct
    // unsigned magnitude 2^(WIDTH-1).
    assign a_mag = (bus.Sign && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign b_mag = (bus.Sign && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // Multiply step: {upper,lower} is the accumulator, multiplier bits are
    // consumed from lower[0] while product bits shift in from the top.
    assign add_sum  = {1'b0, upper} + {1'b0, opnd};
    assign mul_next = lower[0] ? add_sum : {1'b0, upper};

    // Divide step: upper is the partial remainder, lower shifts dividend bits
    // out of its MSB and quotient bits into its LSB.
    assign shifted = {upper, lower[WIDTH-1]};
    assign diff    = shifted - {1'b0, opnd};

    // Sign correction. With a zero divisor every trial subtraction succeeds,
    // so the remainder ends up as |A| and the remainder sign fix restores A.
    assign product  = {upper, lower};
    assign prod_fix = q_neg ? -product : product;
    assign quo_fix  = q_neg ? -lower : lower;
    assign rem_fix  = r_neg ? -upper : upper;

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // Control FSM and datapath: capture in IDLE, WIDTH iteration steps in
    // CALC, sign correction and HI/LO write in SIGN. MTHI/MTLO only land in
    // IDLE, so an operation result always wins over a concurrent write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            is_div <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            b_zero <= 1'b0;
            upper  <= '0;
            lower  <= '0;
            opnd   <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we) hi_r <= bus.wdata;
                    if (bus.lo_we) lo_r <= bus.wdata;
                    if (bus.start && !abort_now) begin
                        is_div <= bus.op;
                        q_neg  <= bus.Sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        r_neg  <= bus.Sign & bus.A[WIDTH-1];
                        b_zero <= (bus.B == '0);
                        upper  <= '0;
                        lower  <= a_mag;
                        opnd   <= b_mag;
                        count  <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (abort_now) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            upper <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                            lower <= {lower[WIDTH-2:0], ~diff[WIDTH]};
                        end else begin
                            {upper, lower} <= {mul_next, lower[WIDTH-1:1]};
                        end
                        count <= count + 1'b1;
                        if (count == CW'(WIDTH - 1)) state <= SIGN;
                    end
                end
                SIGN: begin
                    if (!abort_now) begin
                        if (is_div) begin
                            lo_r <= b_zero ? DIV0_LO : quo_fix;
                            hi_r <= rem_fix;
                        end else begin
                            {hi_r, lo_r} <= prod_fix;
                        end
                        done_r <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
// Self-checking bench for mul_div_unit: directed cases plus randomized
// operations compared against an arithmetic reference model.
// Build with MDU_ABORT_EN defined to also exercise the abort path.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;
    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH + 2;

    logic clk = 1'b0;
    logic reset;
`ifdef MDU_ABORT_EN
    logic abort;
`endif

    int testCount = 0;
    int failCount = 0;
    logic [31:0] expHi = '0;
    logic [31:0] expLo = '0;

    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mul_div_unit #(
        .WIDTH   (WIDTH),
        .DIV0_LO (32'hFFFFFFFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MDU_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference model straight from the arithmetic definition.
    task automatic modelOp(input logic op, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, sq, sr;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        if (!op) begin
            if (sgn) p = 64'(sa * sb);
            else     p = {32'b0, a} * {32'b0, b};
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            l = 32'hFFFFFFFF;
            h = a;
        end else if (sgn) begin
            sq = sa / sb;
            sr = sa % sb;
            l = 32'(sq);
            h = 32'(sr);
        end else begin
            l = a / b;
            h = a % b;
        end
    endtask

    // MTHI/MTLO write while idle, checked on the following cycle.
    task automatic writeReg(input logic hiWe, input logic loWe, input logic [31:0] data,
                            input string tag);
        @(negedge clk);
        bus.hi_we = hiWe;
        bus.lo_we = loWe;
        bus.wdata = data;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        if (hiWe) expHi = data;
        if (loWe) expLo = data;
        checkOutput({tag, "_hi"}, 64'(bus.hi), 64'(expHi));
        checkOutput({tag, "_lo"}, 64'(bus.lo), 64'(expLo));
    endtask

    // Issue one operation and follow it to completion. injectAt > 0 drives a
    // second start plus an MTLO pulse at that cycle; withWrite fires MTHI/MTLO
    // in the same cycle as start.
    task automatic applyStimulus(input logic op, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input int injectAt, input logic withWrite,
                                 input string tag);
        int cycles;
        int busyDrop;
        logic [31:0] wd;
        modelOp(op, sgn, a, b, expHi, expLo);
        wd = $urandom;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.Sign  = sgn;
        bus.A     = a;
        bus.B     = b;
        if (withWrite) begin
            bus.hi_we = 1'b1;
            bus.lo_we = 1'b1;
            bus.wdata = wd;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.op    = ~op;
        bus.Sign  = ~sgn;
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd1);
        if (withWrite) checkOutput({tag, "_wr_hi"}, 64'(bus.hi), 64'(wd));
        cycles   = 0;
        busyDrop = 0;
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (bus.done) break;
            if (!bus.busy) busyDrop++;
            if (cycles == injectAt) begin
                bus.start = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = $urandom;
            end else begin
                bus.start = 1'b0;
                bus.lo_we = 1'b0;
            end
        end
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        checkOutput({tag, "_latency"}, 64'(cycles), 64'(LATENCY));
        checkOutput({tag, "_busy_gaps"}, 64'(busyDrop), 64'd0);
        checkOutput({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
        checkOutput({tag, "_hi"}, 64'(bus.hi), 64'(expHi));
        checkOutput({tag, "_lo"}, 64'(bus.lo), 64'(expLo));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    // Watch for a spurious done pulse over a fixed window.
    task automatic watchNoDone(input int n, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        checkOutput(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rop, rsg;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.Sign  = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
`ifdef MDU_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_hi", 64'(bus.hi), 64'd0);
        checkOutput("reset_lo", 64'(bus.lo), 64'd0);

        applyStimulus(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, "multu_max");
        checkOutput("multu_max_hi_const", 64'(bus.hi), 64'hFFFFFFFE);
        applyStimulus(1'b0, 1'b1, 32'hFFFFFFFD, 32'd7, 0, 1'b0, "mult_neg");
        checkOutput("mult_neg_lo_const", 64'(bus.lo), 64'hFFFFFFEB);
        applyStimulus(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 0, 1'b0, "div_neg");
        checkOutput("div_neg_lo_const", 64'(bus.lo), 64'hFFFFFFFD);
        applyStimulus(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, "div_ovf");
        checkOutput("div_ovf_lo_const", 64'(bus.lo), 64'h80000000);
        applyStimulus(1'b1, 1'b0, 32'd100, 32'd0, 0, 1'b0, "divu_zero");
        checkOutput("divu_zero_hi_const", 64'(bus.hi), 64'd100);
        applyStimulus(1'b1, 1'b1, 32'hFFFFFF00, 32'd0, 0, 1'b0, "div_zero_neg");

        writeReg(1'b1, 1'b0, 32'h1234, "mthi");
        applyStimulus(1'b1, 1'b0, 32'd10, 32'd3, 5, 1'b0, "divu_inject");
        checkOutput("divu_inject_lo_const", 64'(bus.lo), 64'd3);
        applyStimulus(1'b0, 1'b1, 32'h12345678, 32'hFEDCBA98, 0, 1'b1, "mult_wr_start");

        // Asynchronous reset in the middle of MULTU 5x6.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.Sign  = 1'b0;
        bus.A     = 32'd5;
        bus.B     = 32'd6;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_mid_hi", 64'(bus.hi), 64'd0);
        checkOutput("rst_mid_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        expHi = '0;
        expLo = '0;
        watchNoDone(40, "rst_mid_no_done");
        applyStimulus(1'b0, 1'b0, 32'd5, 32'd6, 0, 1'b0, "multu_after_rst");

`ifdef MDU_ABORT_EN
        writeReg(1'b1, 1'b1, 32'hAA, "abort_pre");
        writeReg(1'b0, 1'b1, 32'hBB, "abort_pre2");
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.Sign  = 1'b1;
        bus.A     = 32'd77;
        bus.B     = 32'd99;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_hi", 64'(bus.hi), 64'hAA);
        checkOutput("abort_lo", 64'(bus.lo), 64'hBB);
        watchNoDone(40, "abort_no_done");
        @(negedge clk);
        abort     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        bus.start = 1'b0;
        checkOutput("abort_start_ignored", 64'(bus.busy), 64'd0);
        applyStimulus(1'b0, 1'b1, 32'd77, 32'd99, 0, 1'b0, "after_abort");
`endif

        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom);
            rsg = 1'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = $urandom_range(1, 15);
                3: ra = $urandom_range(0, 255);
                default: ;
            endcase
            if (i % 8 == 0) writeReg(1'($urandom), 1'($urandom), $urandom, "rand_mt");
            applyStimulus(rop, rsg, ra, rb, 0, 1'b0, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS pipeline; executes MULT, MULTU, DIV and DIVU and owns the HI/LO registers.
- The EX stage issues an operation with a start pulse and stalls on busy. The unit returns results through HI/LO, which are read by MFHI/MFLO and written by MTHI/MTLO.
- Sits beside the combinational ALU in EX, with the same operand sources (A = rs, B = rt) and the same Sign convention.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.
- DIV0_LO, 32'hFFFFFFFF, value written to LO on divide-by-zero.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  issue pulse; sampled only in IDLE
- op  input  1  0 = multiply, 1 = divide
- Sign  input  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU)
- A  input  WIDTH  multiplicand / dividend
- B  input  WIDTH  multiplier / divisor
- hi_we  input  1  MTHI write strobe
- lo_we  input  1  MTLO write strobe
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in flight; pipeline must stall MD/MFHI/MFLO/MTHI/MTLO
- done  output  1  one-cycle pulse after HI/LO are updated by an operation
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- abort  input  1  present only with MDU_ABORT_EN

Behaviour:
- Reset (async, active-high): state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, counter = 0, internal datapath registers = 0.
- States:
  - IDLE: if start, latch op and Sign, latch |A| and |B| (magnitudes when Sign = 1, raw values otherwise), record result signs, counter = 0, go to CALC.
  - CALC: one radix-2 step per cycle.
    - Multiply: shift-add on a 2×WIDTH accumulator.
    - Divide: restoring shift-subtract on a remainder/quotient pair.
    - counter increments; after step WIDTH-1, go to SIGN.
  - SIGN: apply sign correction, write hi/lo, assert done for the next cycle, go to IDLE.
- busy = (state != IDLE), decoded from the state register with no combinational path from start.
- Timing: start sampled at edge E0; busy is high after E0; hi/lo are written at edge E0+WIDTH+1; busy drops and done = 1 in the cycle after that edge. Total latency is WIDTH+2 cycles, i.e. 34 for WIDTH = 32.
- Multiply result: {hi, lo} = product. For signed, the 2×WIDTH product is negated iff A[MSB] xor B[MSB].
- Divide result: lo = quotient, hi = remainder.
  - Signed: quotient negated iff sign(A) xor sign(B); remainder takes sign(A).
  - INT_MIN / -1 (signed): lo = 32'h80000000, hi = 0. No trap.
- Divide-by-zero (B = 0): same latency; lo = DIV0_LO, hi = A unmodified, regardless of Sign.
- start while busy: ignored; no queueing.
- hi_we/lo_we:
  - In IDLE: register updates at the next edge.
  - While busy: dropped.
  - Simultaneous with start in IDLE: the write lands, and the operation later overwrites both registers.
  - In the completion cycle (SIGN): the operation result wins.
- Operands are captured at start; changes to A/B/op/Sign during CALC have no effect.
- Async reset mid-operation: operation discarded, hi/lo cleared, done is not pulsed.

Optional Feature:
- Macro: MDU_ABORT_EN.
- Defined:
  - abort port exists, driven by the exception/flush logic.
  - abort = 1 in CALC or SIGN returns to IDLE at the next edge; hi/lo are unchanged and done is not pulsed.
  - abort in IDLE has no effect. abort together with start in IDLE: start is ignored.
- Undefined: port absent; an operation always runs to completion.

Test Plan:
- MULTU A = 32'hFFFFFFFF, B = 32'hFFFFFFFF, start 1 cycle -> busy for 34 cycles; hi = 32'hFFFFFFFE, lo = 32'h00000001; done high exactly one cycle.
- MULT A = -3 (32'hFFFFFFFD), B = 7 -> hi = 32'hFFFFFFFF, lo = 32'hFFFFFFEB. Then DIV A = -7, B = 2 -> lo = 32'hFFFFFFFD, hi = 32'hFFFFFFFF.
- DIV A = 32'h80000000, B = 32'hFFFFFFFF -> lo = 32'h80000000, hi = 0. DIVU A = 100, B = 0 -> lo = 32'hFFFFFFFF, hi = 100.
- hi_we = 1, wdata = 32'h1234 in IDLE -> hi = 32'h1234 next cycle. Start DIVU 10/3 with a second start and lo_we pulse at cycle 5 -> both ignored; final lo = 3, hi = 1; latency still 34.
- Assert reset at cycle 10 of MULTU 5×6 -> busy = 0, hi = lo = 0 immediately, no done pulse. A fresh MULTU 5×6 then gives lo = 30, hi = 0.
- MDU_ABORT_EN: start MULT with hi = 32'hAA, lo = 32'hBB preloaded, abort at cycle 12 -> IDLE next edge; hi/lo stay 32'hAA/32'hBB; no done pulse; next start is accepted.
